// File: rtl/csadd32_arbiter.sv
// Round-robin share of one carry-select 32-bit adder among N valid/ready requesters.
// Grant-to-result latency 2 cycles; the result is held in HOLD until resp_ready, and no new grant is made meanwhile.

module csadd32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [8:0] c;

  assign c[0] = cin;

  // Each 4-bit block precomputes both carry-in cases; the incoming carry only steers the muxes.
  for (genvar g = 0; g < 8; g++) begin : g_blk
    logic [4:0] s0;
    logic [4:0] s1;
    assign s0 = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]};
    assign s1 = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]} + 5'd1;
    assign sum[4*g +: 4] = c[g] ? s1[3:0] : s0[3:0];
    assign c[g+1]        = c[g] ? s1[4]   : s0[4];
  end

  assign cout = c[8];
endmodule

module csadd32_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [32*N-1:0]   req_a,
  input  logic [32*N-1:0]   req_b,
  input  logic [N-1:0]      req_cin,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [ID_W-1:0]   resp_id,
  output logic [31:0]       resp_sum,
  output logic              resp_cout
);
  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] op_id_q, op_id_d;
  logic [ID_W-1:0] resp_id_q, resp_id_d;
  logic [31:0]     op_a_q, op_a_d;
  logic [31:0]     op_b_q, op_b_d;
  logic            op_cin_q, op_cin_d;
  logic [31:0]     resp_sum_q, resp_sum_d;
  logic            resp_cout_q, resp_cout_d;

  logic [2*N-1:0]  rot;
  logic [ID_W-1:0] win;
  logic            found;
  logic [31:0]     sum_w;
  logic            cout_w;
  int              w;

  csadd32 u_add (
    .a   (op_a_q),
    .b   (op_b_q),
    .cin (op_cin_q),
    .sum (sum_w),
    .cout(cout_w)
  );

  // Rotating the doubled valid vector by ptr turns the wrap-around search into a plain lowest-bit search.
  always_comb begin
    rot   = {req_valid, req_valid} >> ptr_q;
    found = 1'b0;
    win   = '0;
    w     = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        w     = int'(ptr_q) + k;
        if (w >= N) w = w - N;
        win   = ID_W'(w);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && !rst && found) req_ready = {{(N-1){1'b0}}, 1'b1} << win;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_id_d     = op_id_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_cin_d    = op_cin_q;
    resp_id_d   = resp_id_q;
    resp_sum_d  = resp_sum_q;
    resp_cout_d = resp_cout_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          op_a_d   = req_a[32*win +: 32];
          op_b_d   = req_b[32*win +: 32];
          op_cin_d = req_cin[win];
          op_id_d  = win;
          ptr_d    = (win == ID_W'(N-1)) ? '0 : win + ID_W'(1);
          state_d  = CALC;
        end
      end
      CALC: begin
        resp_sum_d  = sum_w;
        resp_cout_d = cout_w;
        resp_id_d   = op_id_q;
        state_d     = HOLD;
      end
      HOLD: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      op_id_q     <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_cin_q    <= 1'b0;
      resp_id_q   <= '0;
      resp_sum_q  <= '0;
      resp_cout_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_id_q     <= op_id_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_cin_q    <= op_cin_d;
      resp_id_q   <= resp_id_d;
      resp_sum_q  <= resp_sum_d;
      resp_cout_q <= resp_cout_d;
    end
  end

  assign resp_valid = (state_q == HOLD);
  assign resp_id    = resp_id_q;
  assign resp_sum   = resp_sum_q;
  assign resp_cout  = resp_cout_q;
endmodule
